// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package riscv_mem_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned BE_W       = XLEN / 8;
    localparam int unsigned FAIR_LIMIT = 2;
    localparam int unsigned FAIR_CNT_W = 2;

    localparam logic [XLEN-1:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } arb_state_t;

    // Attributes of a data access that outlive the grant cycle
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [1:0] size;
        logic       is_unsigned;
    } dm_ctx_t;

    typedef struct packed {
        logic            req;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } bus_cmd_t;

endpackage

// File: rtl/mem_align_unit.sv
// Byte-lane steering: store byte enables/replication, load lane select/extension,
// and alignment check for one data access.
module mem_align_unit
    import riscv_mem_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be         = '0;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be        = BE_W'(4'b0001) << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{rd_byte[7] & ~is_unsigned}}, rd_byte};
            end
            SIZE_HALF: begin
                be         = BE_W'(4'b0011) << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{rd_half[15] & ~is_unsigned}}, rd_half};
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                be         = '1;
                misaligned = |addr_lo;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-outstanding
// memory bus, with data priority bounded by a fetch fairness counter.
module mem_port_arbiter
    import riscv_mem_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            if_req_in,
    input  logic [XLEN-1:0] if_addr_in,
    output logic [XLEN-1:0] if_rdata_out,
    output logic            if_ack_out,
    input  logic            dm_rd_req_in,
    input  logic            dm_wr_req_in,
    input  logic [XLEN-1:0] dm_addr_in,
    input  logic [XLEN-1:0] dm_wdata_in,
    input  logic [1:0]      dm_size_in,
    input  logic            dm_unsigned_in,
    output logic [XLEN-1:0] dm_rdata_out,
    output logic            dm_ack_out,
    output logic            dm_misaligned_out,
    output logic            bus_req_out,
    output logic            bus_we_out,
    output logic [XLEN-1:0] bus_addr_out,
    output logic [XLEN-1:0] bus_wdata_out,
    output logic [BE_W-1:0] bus_be_out,
    input  logic [XLEN-1:0] bus_rdata_in,
    input  logic            bus_ack_in,
    output logic            stall_out
);

    arb_state_t            state_q, state_d;
    logic [FAIR_CNT_W-1:0] fair_cnt_q, fair_cnt_d;
    dm_ctx_t               ctx_q, ctx_d, au_ctx;
    bus_cmd_t              bus_q, bus_d;
    logic [XLEN-1:0]       if_rdata_d, dm_rdata_d;
    logic                  if_ack_d, dm_ack_d, dm_mis_d;

    logic                  dm_req, can_grant, fetch_turn, grant_dm, grant_if;
    logic [BE_W-1:0]       au_be;
    logic [XLEN-1:0]       au_wdata, au_rdata;
    logic                  au_misaligned;

    // Live request attributes while idle, captured ones while a load is in flight
    always_comb begin
        au_ctx = ctx_q;
        if (state_q == IDLE) begin
            au_ctx.addr_lo     = dm_addr_in[1:0];
            au_ctx.size        = dm_size_in;
            au_ctx.is_unsigned = dm_unsigned_in;
        end
    end

    mem_align_unit u_align (
        .addr_lo     (au_ctx.addr_lo),
        .size        (au_ctx.size),
        .is_unsigned (au_ctx.is_unsigned),
        .wdata       (dm_wdata_in),
        .rdata       (bus_rdata_in),
        .be          (au_be),
        .wdata_rep   (au_wdata),
        .rdata_ext   (au_rdata),
        .misaligned  (au_misaligned)
    );

    assign dm_req     = dm_rd_req_in | dm_wr_req_in;
    assign can_grant  = (state_q == IDLE) & ~if_ack_out & ~dm_ack_out;
    assign fetch_turn = if_req_in & (fair_cnt_q >= FAIR_CNT_W'(FAIR_LIMIT));
    assign grant_dm   = can_grant & dm_req & ~fetch_turn;
    assign grant_if   = can_grant & if_req_in & ~grant_dm;

    assign stall_out = (if_req_in & ~if_ack_out) | (dm_req & ~dm_ack_out);

    assign bus_req_out   = bus_q.req;
    assign bus_we_out    = bus_q.we;
    assign bus_addr_out  = bus_q.addr;
    assign bus_wdata_out = bus_q.wdata;
    assign bus_be_out    = bus_q.be;

    always_comb begin
        state_d    = state_q;
        fair_cnt_d = fair_cnt_q;
        ctx_d      = ctx_q;
        bus_d      = bus_q;
        if_rdata_d = if_rdata_out;
        dm_rdata_d = dm_rdata_out;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        dm_mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    if (fair_cnt_q < FAIR_CNT_W'(FAIR_LIMIT)) begin
                        fair_cnt_d = fair_cnt_q + FAIR_CNT_W'(1);
                    end
                    ctx_d = au_ctx;
                    if (au_misaligned) begin
                        dm_ack_d   = 1'b1;
                        dm_mis_d   = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        state_d     = DM_WAIT;
                        bus_d.req   = 1'b1;
                        bus_d.we    = dm_wr_req_in;
                        bus_d.addr  = dm_addr_in & WORD_ADDR_MASK;
                        bus_d.wdata = au_wdata;
                        bus_d.be    = au_be;
                    end
                end else if (grant_if) begin
                    fair_cnt_d  = '0;
                    state_d     = IF_WAIT;
                    bus_d.req   = 1'b1;
                    bus_d.we    = 1'b0;
                    bus_d.addr  = if_addr_in & WORD_ADDR_MASK;
                    bus_d.wdata = '0;
                    bus_d.be    = '1;
                end
            end
            IF_WAIT: begin
                if (bus_ack_in) begin
                    bus_d.req  = 1'b0;
                    if_rdata_d = bus_rdata_in;
                    if_ack_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            DM_WAIT: begin
                if (bus_ack_in) begin
                    bus_d.req = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!bus_q.we) begin
                        dm_rdata_d = au_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q           <= IDLE;
            fair_cnt_q        <= '0;
            ctx_q             <= '0;
            bus_q             <= '0;
            if_rdata_out      <= '0;
            if_ack_out        <= 1'b0;
            dm_rdata_out      <= '0;
            dm_ack_out        <= 1'b0;
            dm_misaligned_out <= 1'b0;
        end else begin
            state_q           <= state_d;
            fair_cnt_q        <= fair_cnt_d;
            ctx_q             <= ctx_d;
            bus_q             <= bus_d;
            if_rdata_out      <= if_rdata_d;
            if_ack_out        <= if_ack_d;
            dm_rdata_out      <= dm_rdata_d;
            dm_ack_out        <= dm_ack_d;
            dm_misaligned_out <= dm_mis_d;
        end
    end

endmodule
